// File: rtl/cpu_pkg.sv
// Shared definitions for the SIMD multicycle core: widths, opcodes, FSM and lane-mode types.
package cpu_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned ALEN = 10;
  localparam int unsigned ILEN = 18;

  localparam logic [5:0] OP_ADD      = 6'd0;
  localparam logic [5:0] OP_ADDI     = 6'd3;
  localparam logic [5:0] OP_SUB      = 6'd6;
  localparam logic [5:0] OP_SUBI     = 6'd9;
  localparam logic [5:0] OP_MUL      = 6'd12;
  localparam logic [5:0] OP_MULI     = 6'd15;
  localparam logic [5:0] OP_MAC      = 6'd18;
  localparam logic [5:0] OP_LSL      = 6'd21;
  localparam logic [5:0] OP_LSR      = 6'd24;
  localparam logic [5:0] OP_AND      = 6'd27;
  localparam logic [5:0] OP_OR       = 6'd30;
  localparam logic [5:0] OP_NOT      = 6'd33;
  localparam logic [5:0] OP_LOOPJUMP = 6'd36;
  localparam logic [5:0] OP_SETLOOP  = 6'd37;
  localparam logic [5:0] OP_LOAD     = 6'd38;
  localparam logic [5:0] OP_STORE    = 6'd41;
  localparam logic [5:0] OP_SET      = 6'd44;
  localparam logic [5:0] OP_HALT     = 6'd63;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

  typedef enum logic [1:0] {M16 = 2'd0, M8 = 2'd1, M4 = 2'd2} lane_mode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_MUL, ALU_MAC, ALU_SHL, ALU_SHR, ALU_AND, ALU_OR, ALU_NOT
  } alu_op_e;

  // Width variants come in triples; the triples restart at OP_LOAD, and loop ops are single.
  function automatic lane_mode_e op_mode(input logic [5:0] op);
    logic [5:0] rel;
    rel = (op >= OP_LOAD) ? (op - OP_LOAD) : op;
    if (op == OP_LOOPJUMP || op == OP_SETLOOP) rel = 6'd0;
    return lane_mode_e'(2'(rel % 6'd3));
  endfunction

  // Opcode of the 16-bit variant of a width triple.
  function automatic logic [5:0] op_base(input logic [5:0] op);
    return op - {4'd0, op_mode(op)};
  endfunction

endpackage

// File: rtl/cpu_simd_alu.sv
// Combinational lane-partitioned ALU: 1x16, 2x8 or 4x4 independent lanes, no inter-lane carry.
module simd_alu
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] c_i,
  input  alu_op_e         op_i,
  input  lane_mode_e      mode_i,
  output logic [XLEN-1:0] y_o
);

  // Lanes are zero-extended into 16 bits, so truncating the result gives lane-local wrap and fill.
  function automatic logic [XLEN-1:0] calc(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                           input logic [XLEN-1:0] c, input alu_op_e op);
    logic [XLEN-1:0] r;
    unique case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_MUL: r = a * b;
      ALU_MAC: r = c + a * b;
      ALU_SHL: r = a << 1;
      ALU_SHR: r = a >> 1;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_NOT: r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] y16, y8, y4;

  assign y16 = calc(a_i, b_i, c_i, op_i);

  for (genvar i = 0; i < 2; i++) begin : g_m8
    assign y8[i*8 +: 8] = 8'(calc(XLEN'(a_i[i*8 +: 8]), XLEN'(b_i[i*8 +: 8]),
                                  XLEN'(c_i[i*8 +: 8]), op_i));
  end

  for (genvar i = 0; i < 4; i++) begin : g_m4
    assign y4[i*4 +: 4] = 4'(calc(XLEN'(a_i[i*4 +: 4]), XLEN'(b_i[i*4 +: 4]),
                                  XLEN'(c_i[i*4 +: 4]), op_i));
  end

  always_comb begin
    unique case (mode_i)
      M8:      y_o = y8;
      M4:      y_o = y4;
      default: y_o = y16;
    endcase
  end

endmodule

// File: rtl/cpu_top.sv
// Multicycle SIMD core: FETCH/EXEC/MEM/HALT sequencer, register file, loop counter, memory strobes.
module cpu_top
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [ILEN-1:0] instruction_in,
  output logic [ALEN-1:0] instruction_address,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out,
  output logic [ALEN-1:0] data_address,
  output logic            data_r,
  output logic            data_w,
  output logic            done
);

  state_e          state_q, state_d;
  logic [ALEN-1:0] pc_q, pc_d, lc_q, lc_d, daddr_q, daddr_d;
  logic [ILEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] dout_q, dout_d;
  logic            dr_q, dr_d, dw_q, dw_d, done_q, done_d;
  logic [XLEN-1:0] rf_q [4];

  logic            rf_we;
  logic [1:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;

  logic [5:0]      opcode, base;
  lane_mode_e      mode;
  logic [ALEN-1:0] imm;
  logic [1:0]      r_i, rd, rs, rd_mac, ra, rb;
  logic [XLEN-1:0] imm_rep, alu_a, alu_b, alu_c, alu_y;
  alu_op_e         alu_op;
  logic            alu_wr;
  logic [1:0]      alu_dst;

  assign opcode = ir_q[17:12];
  assign base   = op_base(opcode);
  assign mode   = op_mode(opcode);
  assign imm    = ir_q[9:0];
  assign r_i    = ir_q[11:10];
  assign rd     = ir_q[3:2];
  assign rs     = ir_q[1:0];
  assign rd_mac = ir_q[5:4];
  assign ra     = ir_q[3:2];
  assign rb     = ir_q[1:0];

  always_comb begin
    unique case (mode)
      M8:      imm_rep = {2{imm[7:0]}};
      M4:      imm_rep = {4{imm[3:0]}};
      default: imm_rep = XLEN'(imm);
    endcase
  end

  // Operand routing per instruction format; unary ops use the rs field as their register.
  always_comb begin
    alu_op  = ALU_ADD;
    alu_a   = rf_q[rd];
    alu_b   = rf_q[rs];
    alu_c   = '0;
    alu_wr  = 1'b0;
    alu_dst = rd;
    case (base)
      OP_ADD:  alu_wr = 1'b1;
      OP_SUB:  begin alu_op = ALU_SUB; alu_wr = 1'b1; end
      OP_MUL:  begin alu_op = ALU_MUL; alu_wr = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; alu_wr = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  alu_wr = 1'b1; end
      OP_ADDI, OP_SUBI, OP_MULI: begin
        alu_op  = (base == OP_ADDI) ? ALU_ADD : (base == OP_SUBI) ? ALU_SUB : ALU_MUL;
        alu_a   = rf_q[r_i];
        alu_b   = imm_rep;
        alu_dst = r_i;
        alu_wr  = 1'b1;
      end
      OP_MAC: begin
        alu_op  = ALU_MAC;
        alu_a   = rf_q[ra];
        alu_b   = rf_q[rb];
        alu_c   = rf_q[rd_mac];
        alu_dst = rd_mac;
        alu_wr  = 1'b1;
      end
      OP_LSL, OP_LSR, OP_NOT: begin
        alu_op  = (base == OP_LSL) ? ALU_SHL : (base == OP_LSR) ? ALU_SHR : ALU_NOT;
        alu_a   = rf_q[rs];
        alu_dst = rs;
        alu_wr  = 1'b1;
      end
      default: ;
    endcase
  end

  simd_alu u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .c_i    (alu_c),
    .op_i   (alu_op),
    .mode_i (mode),
    .y_o    (alu_y)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lc_d    = lc_q;
    ir_d    = ir_q;
    done_d  = done_q;
    dr_d    = 1'b0;
    dw_d    = 1'b0;
    daddr_d = '0;
    dout_d  = '0;
    rf_we   = 1'b0;
    rf_wa   = alu_dst;
    rf_wd   = alu_y;
    unique case (state_q)
      S_FETCH: begin
        ir_d    = instruction_in;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (base == OP_LOAD || base == OP_STORE) begin
          // Strobes are registered here so they are clean for the whole MEM cycle.
          state_d = S_MEM;
          dr_d    = 1'b1;
          dw_d    = (base == OP_STORE);
          daddr_d = imm;
          dout_d  = (base == OP_STORE) ? rf_q[r_i] : '0;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + ALEN'(1);
          rf_we   = alu_wr;
          case (base)
            OP_SET: begin
              rf_we = 1'b1;
              rf_wa = r_i;
              rf_wd = imm_rep;
            end
            OP_SETLOOP: lc_d = imm;
            OP_LOOPJUMP: begin
              if (lc_q > ALEN'(1)) begin
                lc_d = lc_q - ALEN'(1);
                pc_d = imm;
              end else begin
                lc_d = '0;
              end
            end
            default: ;
          endcase
        end
      end
      S_MEM: begin
        rf_we   = (base == OP_LOAD);
        rf_wa   = r_i;
        rf_wd   = data_in;
        pc_d    = pc_q + ALEN'(1);
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      lc_q    <= '0;
      ir_q    <= '0;
      done_q  <= 1'b0;
      dr_q    <= 1'b0;
      dw_q    <= 1'b0;
      daddr_q <= '0;
      dout_q  <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lc_q    <= lc_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
      dr_q    <= dr_d;
      dw_q    <= dw_d;
      daddr_q <= daddr_d;
      dout_q  <= dout_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

  assign instruction_address = pc_q;
  assign data_r              = dr_q;
  assign data_w              = dw_q;
  assign data_address        = daddr_q;
  assign data_out            = dout_q;
  assign done                = done_q;

endmodule

// File: tb/tb_cpu_top.sv
// Scoreboard bench for cpu_top: expected stores are queued by stimulus and popped by a store monitor.
module tb_cpu_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] instruction_in = '0;
  logic [9:0]  instruction_address, data_address;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_r, data_w, done;

  cpu_top dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction_in      (instruction_in),
    .instruction_address (instruction_address),
    .data_in             (data_in),
    .data_out            (data_out),
    .data_address        (data_address),
    .data_r              (data_r),
    .data_w              (data_w),
    .done                (done)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] HALT_W = {6'd63, 12'd0};

  logic [17:0] imem [1024];
  logic [15:0] dmem [1024];
  logic [15:0] mdm  [1024];
  logic [25:0] exp_q [$];
  logic [25:0] mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pc_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Memories respond on the falling edge.
  always @(negedge clk) begin
    instruction_in = imem[instruction_address];
    if (!rst && data_r) begin
      if (data_w) dmem[data_address] = data_out;
      else        data_in = dmem[data_address];
    end
  end

  // Store monitor.
  always @(negedge clk) begin
    if (!rst && data_r && data_w) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_store: addr 0x%0h data 0x%0h while no store was expected",
                 data_address, data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("store_addr", 32'(data_address), 32'(mon_e[25:16]));
        check("store_data", 32'(data_out), 32'(mon_e[15:0]));
      end
    end
  end

  function automatic logic [17:0] enc_i(input int op, input int r, input int imm);
    return {6'(op), 2'(r), 10'(imm)};
  endfunction
  function automatic logic [17:0] enc_r(input int op, input int rd, input int rs);
    return {6'(op), 8'd0, 2'(rd), 2'(rs)};
  endfunction
  function automatic logic [17:0] enc_m(input int op, input int rd, input int ra, input int rb);
    return {6'(op), 6'd0, 2'(rd), 2'(ra), 2'(rb)};
  endfunction

  task automatic emit(input logic [17:0] ins);
    imem[pc_w] = ins;
    pc_w++;
  endtask

  // Reference model: per-lane integer arithmetic modulo 2^w.
  function automatic logic [15:0] simd(input int grp, input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input int w);
    longint m = longint'(1) << w;
    logic [15:0] res = '0;
    for (int i = 0; i < 16 / w; i++) begin
      longint x = longint'(a >> (i * w)) % m;
      longint y = longint'(b >> (i * w)) % m;
      longint z = longint'(c >> (i * w)) % m;
      longint v;
      case (grp)
        0: v = x + y;
        1: v = x - y + m;
        2: v = x * y;
        3: v = z + x * y;
        4: v = 2 * x;
        5: v = x / 2;
        6: v = x & y;
        7: v = x | y;
        default: v = m - 1 - x;
      endcase
      res = res | 16'((v % m) << (i * w));
    end
    return res;
  endfunction

  function automatic logic [15:0] rep(input int imm, input int w);
    longint m = longint'(1) << w;
    logic [15:0] res = '0;
    for (int i = 0; i < 16 / w; i++) res = res | 16'((longint'(imm) % m) << (i * w));
    return res;
  endfunction

  task automatic model_run();
    logic [15:0] r [4];
    int pc = 0;
    int lc = 0;
    for (int i = 0; i < 4; i++) r[i] = '0;
    mdm = dmem;
    for (int step = 0; step < 5000; step++) begin
      logic [17:0] ins = imem[pc];
      int op  = int'(ins[17:12]);
      int ri  = int'(ins[11:10]);
      int imm = int'(ins[9:0]);
      int f1  = int'(ins[1:0]);
      int f2  = int'(ins[3:2]);
      int f3  = int'(ins[5:4]);
      int nxt = (pc + 1) % 1024;
      int w;
      if (op == 63) break;
      if (op < 36) begin
        w = (op % 3 == 0) ? 16 : (op % 3 == 1) ? 8 : 4;
        case (op / 3)
          0:  r[f2] = simd(0, r[f2], r[f1], '0, w);
          1:  r[ri] = simd(0, r[ri], rep(imm, w), '0, w);
          2:  r[f2] = simd(1, r[f2], r[f1], '0, w);
          3:  r[ri] = simd(1, r[ri], rep(imm, w), '0, w);
          4:  r[f2] = simd(2, r[f2], r[f1], '0, w);
          5:  r[ri] = simd(2, r[ri], rep(imm, w), '0, w);
          6:  r[f3] = simd(3, r[f2], r[f1], r[f3], w);
          7:  r[f1] = simd(4, r[f1], '0, '0, w);
          8:  r[f1] = simd(5, r[f1], '0, '0, w);
          9:  r[f2] = simd(6, r[f2], r[f1], '0, w);
          10: r[f2] = simd(7, r[f2], r[f1], '0, w);
          default: r[f1] = simd(8, r[f1], '0, '0, w);
        endcase
      end else if (op == 36) begin
        if (lc > 1) begin lc--; nxt = imm; end
        else lc = 0;
      end else if (op == 37) begin
        lc = imm;
      end else if (op >= 38 && op <= 40) begin
        r[ri] = mdm[imm];
      end else if (op >= 41 && op <= 43) begin
        mdm[imm] = r[ri];
        exp_q.push_back({10'(imm), r[ri]});
      end else if (op >= 44 && op <= 46) begin
        r[ri] = rep(imm, (op == 44) ? 16 : (op == 45) ? 8 : 4);
      end
      pc = nxt;
    end
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    check({name, "_rst_iaddr"}, 32'(instruction_address), 0);
    check({name, "_rst_done"}, 32'(done), 0);
    check({name, "_rst_strobes"}, 32'({data_r, data_w}), 0);
    check({name, "_rst_daddr"}, 32'(data_address), 0);
    check({name, "_rst_dout"}, 32'(data_out), 0);
    for (int i = 0; i < 1024; i++) imem[i] = HALT_W;
    pc_w = 0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic finish_prog(input string name, input int halt_at);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_done"}, 32'(done), 1);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_pending_stores"}, 32'(exp_q.size()), 0);
    check({name, "_halt_pc"}, 32'(instruction_address), 32'(halt_at));
    check({name, "_done_held"}, 32'(done), 1);
    check({name, "_strobes_idle"}, 32'({data_r, data_w}), 0);
    exp_q.delete();
  endtask

  task automatic test_load_add();
    do_reset("load_add");
    dmem[0] = 16'd5;
    dmem[1] = 16'd15;
    emit(enc_i(38, 0, 0));
    emit(enc_i(38, 1, 1));
    emit(enc_r(0, 0, 1));
    emit(enc_i(41, 0, 0));
    emit(HALT_W);
    exp_q.push_back({10'd0, 16'h0014});
    release_rst();
    finish_prog("load_add", 4);
    check("load_add_mem0", 32'(dmem[0]), 32'h0014);
  endtask

  task automatic test_lanes();
    int body;
    do_reset("lanes");
    dmem[20] = 16'h85BA;
    emit(enc_i(44, 0, 'h18));  emit(enc_i(45, 1, 'h5A));
    emit(enc_r(1, 0, 1));      emit(enc_i(41, 0, 10));
    exp_q.push_back({10'd10, 16'h5A72});
    emit(enc_i(44, 2, 'h152)); emit(enc_r(13, 2, 1));  emit(enc_i(41, 2, 11));
    exp_q.push_back({10'd11, 16'h5AD4});
    emit(enc_r(25, 0, 2));     emit(enc_i(41, 2, 12));
    exp_q.push_back({10'd12, 16'h2D6A});
    emit(enc_i(38, 0, 20));    emit(enc_r(21, 0, 0));  emit(enc_i(41, 0, 13));
    exp_q.push_back({10'd13, 16'h0B74});
    emit(enc_i(44, 1, 'h68));  emit(enc_i(4, 1, 'hE)); emit(enc_i(41, 1, 14));
    exp_q.push_back({10'd14, 16'h0E76});
    emit(enc_i(44, 1, 'h68));  emit(enc_r(34, 0, 1));  emit(enc_i(41, 1, 15));
    exp_q.push_back({10'd15, 16'hFF97});
    emit(enc_i(46, 0, 'hF));   emit(enc_i(46, 1, 4));  emit(enc_i(46, 2, 2));
    emit(enc_m(20, 0, 1, 2));  emit(enc_i(41, 0, 16));
    exp_q.push_back({10'd16, 16'h7777});
    emit(enc_i(11, 0, 8));     emit(enc_i(41, 0, 17));
    exp_q.push_back({10'd17, 16'hFFFF});
    emit(enc_i(44, 0, 7));     emit(enc_i(37, 0, 2));
    body = pc_w;
    emit(enc_i(3, 0, 1));      emit(enc_i(36, 0, body)); emit(enc_i(41, 0, 18));
    exp_q.push_back({10'd18, 16'h0009});
    emit(HALT_W);
    release_rst();
    finish_prog("lanes", pc_w - 1);
  endtask

  task automatic test_reset_in_store();
    int cyc = 0;
    bit seen = 1'b0;
    do_reset("rst_store");
    dmem[5] = 16'hBEEF;
    emit(enc_i(44, 0, 'h123));
    emit(enc_i(41, 0, 5));
    emit(HALT_W);
    release_rst();
    while (!seen && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
      if (data_r && data_w) seen = 1'b1;
    end
    check("rst_store_reached_mem", 32'(seen), 1);
    rst = 1'b1;
    #1;
    check("rst_store_data_r", 32'(data_r), 0);
    check("rst_store_data_w", 32'(data_w), 0);
    @(negedge clk);
    #1;
    check("rst_store_mem_kept", 32'(dmem[5]), 32'hBEEF);
    exp_q.push_back({10'd5, 16'h0123});
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_store_restart_pc", 32'(instruction_address), 0);
    finish_prog("rst_store", 2);
  endtask

  task automatic test_random(input int idx);
    string nm = $sformatf("rand%0d", idx);
    int halt_at;
    do_reset(nm);
    for (int k = 200; k < 204; k++) dmem[k] = 16'($urandom);
    for (int k = 0; k < 3; k++) emit(enc_i(44 + $urandom_range(0, 2), k, $urandom_range(0, 1023)));
    for (int k = 0; k < 24; k++) begin
      int c = $urandom_range(0, 9);
      if (c < 6)       emit({6'($urandom_range(0, 35)), 12'($urandom)});
      else if (c == 6) emit(enc_i(38 + $urandom_range(0, 2), $urandom_range(0, 3), 200 + $urandom_range(0, 3)));
      else if (c == 7) emit(enc_i(41 + $urandom_range(0, 2), $urandom_range(0, 3), 300 + $urandom_range(0, 3)));
      else if (c == 8) emit(enc_i(44 + $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 1023)));
      else             emit({6'($urandom_range(47, 62)), 12'($urandom)});
    end
    for (int k = 0; k < 3; k++) emit(enc_i(41, k, 100 + k));
    halt_at = pc_w;
    emit(HALT_W);
    model_run();
    release_rst();
    finish_prog(nm, halt_at);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = '0;
    repeat (2) @(negedge clk);
    test_load_add();
    test_lanes();
    test_reset_in_store();
    for (int p = 0; p < 25; p++) test_random(p);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_top.md
# cpu_top

`cpu_top` is a multicycle SIMD processor core. It fetches 18-bit instructions from an external instruction memory and operates on a small 16-bit register file. Arithmetic and logic instructions run in one of three partition modes: 1×16-bit (H), 2×8-bit (O) or 4×4-bit (Q) lanes. It loads and stores 16-bit words through an external single-port data memory, supports one hardware loop counter, and signals completion on a halt instruction.

## Interface
Parameters: none; all widths below are fixed.

Ports:
- `clk` in 1: single system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instruction_in` in 18: instruction word; memory returns `INST[instruction_address]` after the falling edge.
- `instruction_address` out 10: equals the PC.
- `data_in` in 16: read data; valid from the falling edge of a read cycle until the next rising edge.
- `data_out` out 16: write data.
- `data_address` out 10: data word address.
- `data_r` out 1: memory access enable.
- `data_w` out 1: write qualifier. `data_r=1, data_w=1` means write; `data_r=1, data_w=0` means read.
- `done` out 1: high once a halt instruction has executed.

## Operation
Register file: four 16-bit registers, R0–R3; software uses R0–R2. There is also a 10-bit loop counter LC and a 10-bit PC.

Instruction fields: opcode in [17:12].
- R-type: rd=[3:2], rs=[1:0].
- I-type: r=[11:10], imm=[9:0].
- Unary: r=[1:0].
- MAC: rd=[5:4], ra=[3:2], rb=[1:0].

Lane semantics: every lane op works independently per lane. Results wrap modulo 2^lanewidth and no carry crosses a lane boundary.

Opcodes (decimal), listed as 16/8/4-bit variants:
- 0/1/2 add: rd=rd+rs.
- 3/4/5 addi: r=r+imm.
- 6/7/8 sub: rd=rd−rs.
- 9/10/11 subi: r=r−imm.
- 12/13/14 mul: rd=low lane bits of rd×rs.
- 15/16/17 muli: r=r×imm.
- 18/19/20 mac: rd=rd+ra×rb, truncated per lane.
- 21/22/23 lsl: r=r<<1 per lane, zero fill.
- 24/25/26 lsr: r=r>>1 per lane, zero fill.
- 27/28/29 and; 30/31/32 or: rd=rd op rs.
- 33/34/35 not: r=~r.
- 36 loopjump: if LC>1 then LC−−, PC=imm; otherwise LC=0, PC+1. A loop body therefore runs LC times.
- 37 setloop: LC=imm.
- 38/39/40 load: r=MEM[imm]. All three widths load the full word.
- 41/42/43 store: MEM[imm]=r. All three widths store the full word.
- 44/45/46 set: r=imm.
- 63 halt.
- Any other opcode is a NOP (PC+1).

Immediate operand per mode:
- 16-bit: imm zero-extended.
- 8-bit: imm[7:0] replicated into both lanes.
- 4-bit: imm[3:0] replicated into all four lanes.
- Examples: set8 0x05A gives 0x5A5A; set4 0x05A gives 0xAAAA.

FSM states: FETCH, EXEC, MEM, HALT.
- FETCH: drives PC on `instruction_address`. On the rising edge, IR<=`instruction_in`; go to EXEC.
- EXEC: non-memory instructions write back, update PC (PC+1 or jump target; 10-bit wrap) and go to FETCH. Load/store go to MEM. Halt goes to HALT.
- MEM: `data_address`=IR[9:0], `data_r`=1, `data_w`=store. `data_out`=R[r] for a store, 0 otherwise. On the rising edge a load writes `data_in` into R[r]; PC+1; go to FETCH.
- HALT: `done`=1, all strobes low, PC frozen. Stays until reset.

Outputs: `data_r`, `data_w`, `data_address` and `data_out` are registered or decoded from state and IR. `data_r` and `data_w` are 0 outside MEM.

## Timing
- Reset values: PC=0, R0–R3=0, LC=0, IR=0, state=FETCH, `done`=0, `data_r`=0, `data_w`=0, `data_address`=0, `data_out`=0, `instruction_address`=0.
- Reset mid-operation:
  - Strobes drop immediately, even during MEM; no write completes.
  - Fetching restarts at PC 0 on the first rising edge after `rst` falls.
- Latency:
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - Load/store: 3 cycles (FETCH, EXEC, MEM).
  - The memory samples address and data at the falling edge inside MEM.
- `done` rises on the rising edge that ends EXEC of the halt instruction.

## Structure
- Package `cpu_pkg`:
  - Opcode localparams.
  - FSM state enum.
  - Lane-mode enum (M16, M8, M4) with a function mapping opcode to mode.
- Sub-module `simd_alu`:
  - Combinational.
  - Inputs: a, b, c (16 bits each), op class, lane mode.
  - Output: 16-bit result.
  - Implements add, sub, mul, mac, shl, shr, and, or, not with lane partitioning.
- `cpu_top` holds the FSM, PC, LC, IR, register file, immediate replication and memory strobes.

## Test plan
- Load and add: MEM0=5, MEM1=15; load16 R0←MEM0, R1←MEM1; add16 R0,R1; store16 R0→MEM0. Expect MEM0=0x0014, written with `data_r`=`data_w`=1.
- Lane add and mul:
  - set8 R1, 0x05A gives 0x5A5A. With R0=0x0018, add8 R0,R1 gives 0x5A72.
  - R2=0x0152, R1=0x5A5A, mul8 R2,R1 gives 0x5AD4.
- MAC4: set4 R0/R1/R2 with 0x00F/0x004/0x002 (0xFFFF/0x4444/0x2222); mac4 gives R0=0x7777. Then subi4 0x008 gives 0xFFFF.
- Shifts and immediates:
  - lsr8 on 0x5AD4 gives 0x2D6A.
  - lsl16 on 0x85BA gives 0x0B74.
  - addi8 0x00E on 0x0068 gives 0x0E76.
  - not8 on 0x0068 gives 0xFF97.
- Loop and halt: setloop 2, a body that increments R0 once, then loopjump back to the body. Expect R0 +2. Halt sets `done`=1 and it stays high with no further fetch.
- Reset during a store's MEM cycle: `data_r`/`data_w` go low at once, MEM is unchanged, and after release `instruction_address`=0.
